do_tan_so: RTL and testbench
============================

DO_TAN_SO -- requirements
Module: do_tan_so

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000, is the gate window length in clki cycles (1 s at 100 MHz).
REQ-002 Parameter CNT_W, default 32, is the width of the edge counter and the result.
REQ-003 clki  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  measurement enable; level-sensitive, synchronous to clki.
REQ-006 sig_i  input  1  pulse train under measurement; asynchronous to clki.
REQ-007 freq_o  output  CNT_W  rising-edge count of the last completed gate window.
REQ-008 valid_o  output  1  one-cycle strobe; freq_o/ovf_o updated this cycle.
REQ-009 ovf_o  output  1  last completed window saturated the edge counter.
REQ-010 busy_o  output  1  high while a gate window is in progress.

Function
REQ-011 sig_i SHALL pass a 2-flop synchronizer, then a registered rising-edge detector; an edge pulse SHALL appear exactly 3 clki cycles after the sig_i rise that is sampled.
REQ-012 An edge pulse SHALL be one cycle wide; the minimum resolvable sig_i high and low times SHALL each be 2 clki cycles.
REQ-013 FSM states: IDLE, MEASURE.
REQ-014 IDLE: gate counter and edge counter held at 0; busy_o=0; IDLE->MEASURE on the first cycle with en=1.
REQ-015 MEASURE: gate counter SHALL count 0..GATE_CYCLES-1; busy_o=1; edge counter SHALL increment on every edge pulse.
REQ-016 On the cycle with gate count = GATE_CYCLES-1, freq_o SHALL load edge count plus that cycle's edge pulse, and valid_o SHALL pulse on the following cycle.
REQ-017 Back-to-back windows SHALL have no dead cycle: gate and edge counters SHALL restart at 0 the cycle after the terminal cycle while en=1.
REQ-018 An edge pulse in a terminal cycle SHALL count in the ending window only.
REQ-019 The edge counter SHALL saturate at 2^CNT_W-1, never wrap; ovf_o SHALL load with freq_o as 1 if saturation occurred in that window, else 0.
REQ-020 en deasserted mid-window: abort; next cycle IDLE; no valid_o; freq_o and ovf_o hold previous values.
REQ-021 en deasserted on the terminal cycle: window completes normally (result and valid_o issued), then IDLE.
REQ-022 freq_o and ovf_o SHALL change only in the cycle before valid_o.
REQ-023 Synchronizer flops SHALL run in IDLE too, so the first MEASURE window sees no spurious edge.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, all counters 0, synchronizer and edge-detect flops 0, freq_o=0, valid_o=0, ovf_o=0, busy_o=0.
REQ-025 Reset asserted mid-window SHALL discard that window; no valid_o after release until a full window completes.
REQ-026 Reset release SHALL take effect on the first clki rising edge after rst_n goes high.

Structure
REQ-027 State encodings and default CNT_W/GATE_CYCLES SHALL live in a shared parameter include file used by all pulse blocks.
REQ-028 Synchronizer plus edge detector SHALL be one sub-module, dong_bo_canh (ports clki, rst_n, d_i, rise_o).
REQ-029 Gate counter width SHALL be derived as clog2(GATE_CYCLES).

Verification (sim with GATE_CYCLES=1000, CNT_W=8 unless noted)
REQ-030 en=1, sig_i period 10 clki (5 high/5 low) -> valid_o every 1000 cycles, freq_o=100, ovf_o=0.
REQ-031 sig_i held constant 0 for a window -> freq_o=0, valid_o still strobes; sig_i period 4 -> freq_o=250 within +/-1.
REQ-032 sig_i period 2 with GATE_CYCLES=1000, CNT_W=8 -> ovf_o=1, freq_o=255.
REQ-033 en dropped at cycle 500 of a window -> no valid_o, freq_o holds prior 100; re-raise -> next valid_o exactly 1000 cycles after IDLE->MEASURE plus 1.
REQ-034 Edge pulse forced on terminal cycle -> counted in ending window; next window starts at 0.
REQ-035 rst_n pulsed low mid-window, asynchronous to clki -> all outputs 0 immediately; first valid_o a full window after release.

Source files
------------

// File: rtl/do_tan_so_pkg.sv
// Shared parameters and state encoding for the pulse-measurement blocks.
package do_tan_so_pkg;

  localparam int unsigned DefGateCycles = 100000000;
  localparam int unsigned DefCntW       = 32;

  typedef enum logic {
    StIdle    = 1'b0,
    StMeasure = 1'b1
  } state_e;

  // Width of a counter that spans 0..n-1; never narrower than one bit.
  function automatic int unsigned gate_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dong_bo_canh.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module dong_bo_canh (
  input  logic clki,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_rise;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= d_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_rise  <= r_sync2 & ~r_sync3;
    end
  end

  assign rise_o = r_rise;

endmodule

// File: rtl/do_tan_so.sv
// Frequency counter: counts sig_i rising edges over a fixed gate window of clki cycles.
module do_tan_so
  import do_tan_so_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DefGateCycles,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_i,
  output logic [CNT_W-1:0] freq_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int unsigned           GateW    = gate_w(GATE_CYCLES);
  localparam logic [GateW-1:0]      GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CntMax   = {CNT_W{1'b1}};

  state_e             r_state, w_state_d;
  logic [GateW-1:0]   r_gate, w_gate_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_sat, w_sat_d;
  logic [CNT_W-1:0]   r_freq, w_freq_d;
  logic               r_ovf, w_ovf_d;
  logic               r_valid, w_valid_d;

  logic               w_rise;
  logic               w_terminal;
  logic               w_sat_hit;
  logic [CNT_W-1:0]   w_cnt_inc;

  dong_bo_canh u_dong_bo_canh (
    .clki   (clki),
    .rst_n  (rst_n),
    .d_i    (sig_i),
    .rise_o (w_rise)
  );

  always_comb begin
    w_terminal = (r_gate == GateLast);
    // An edge arriving while the counter is already full is dropped and flagged.
    w_sat_hit  = w_rise && (r_cnt == CntMax);
    w_cnt_inc  = (w_rise && !w_sat_hit) ? r_cnt + CNT_W'(1) : r_cnt;

    w_state_d = r_state;
    w_gate_d  = r_gate;
    w_cnt_d   = r_cnt;
    w_sat_d   = r_sat;
    w_freq_d  = r_freq;
    w_ovf_d   = r_ovf;
    w_valid_d = 1'b0;

    case (r_state)
      StIdle: begin
        w_gate_d = '0;
        w_cnt_d  = '0;
        w_sat_d  = 1'b0;
        if (en) w_state_d = StMeasure;
      end
      StMeasure: begin
        if (w_terminal) begin
          w_freq_d  = w_cnt_inc;
          w_ovf_d   = r_sat | w_sat_hit;
          w_valid_d = 1'b1;
          w_gate_d  = '0;
          w_cnt_d   = '0;
          w_sat_d   = 1'b0;
          if (!en) w_state_d = StIdle;
        end else if (!en) begin
          w_state_d = StIdle;
          w_gate_d  = '0;
          w_cnt_d   = '0;
          w_sat_d   = 1'b0;
        end else begin
          w_gate_d = r_gate + GateW'(1);
          w_cnt_d  = w_cnt_inc;
          w_sat_d  = r_sat | w_sat_hit;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gate  <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_freq  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_gate  <= w_gate_d;
      r_cnt   <= w_cnt_d;
      r_sat   <= w_sat_d;
      r_freq  <= w_freq_d;
      r_ovf   <= w_ovf_d;
      r_valid <= w_valid_d;
    end
  end

  assign freq_o  = r_freq;
  assign valid_o = r_valid;
  assign ovf_o   = r_ovf;
  assign busy_o  = (r_state == StMeasure);

endmodule

// File: tb/tb_do_tan_so.sv
// Randomized bench for do_tan_so against a window-level behavioural model.
module tb_do_tan_so;

  localparam int G  = 1000;
  localparam int CW = 8;
  localparam int CntMax = 255;

  logic          clki  = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          sig_i = 1'b0;
  logic [CW-1:0] freq_o;
  logic          valid_o;
  logic          ovf_o;
  logic          busy_o;

  always #5 clki = ~clki;

  do_tan_so #(
    .GATE_CYCLES (G),
    .CNT_W       (CW)
  ) u_dut (
    .clki    (clki),
    .rst_n   (rst_n),
    .en      (en),
    .sig_i   (sig_i),
    .freq_o  (freq_o),
    .valid_o (valid_o),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: window position, unbounded edge count, last result.
  bit m_busy;
  int m_pos;
  int m_cnt;
  int m_freq;
  bit m_ovf;
  bit m_valid;
  bit hist [4];  // sig_i as sampled on the previous 1..4 edges

  // Stimulus state
  int mode;
  int per;
  int ph;
  int rnd_left;
  int dir_kind;
  int dir_skip;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_pos   = 0;
    m_cnt   = 0;
    m_freq  = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 1'b0;
  endtask

  task automatic set_mode(input int m, input int p, input int k);
    mode     = m;
    per      = p;
    ph       = 0;
    dir_kind = k;
    dir_skip = 2;
  endtask

  task automatic next_sig();
    case (mode)
      1: begin
        ph    = (ph + 1) % per;
        sig_i = (ph < per / 2);
      end
      2: begin
        if (rnd_left == 0) begin
          sig_i    = ~sig_i;
          rnd_left = $urandom_range(1, 6);
        end else begin
          rnd_left--;
        end
      end
      default: sig_i = 1'b0;
    endcase
  endtask

  task automatic tick();
    bit pulse;
    int tot;
    @(posedge clki);
    if (rst_n) begin
      // An edge counts three edges after the first sampled-high edge following a low one.
      pulse   = hist[2] & ~hist[3];
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = sig_i;
      m_valid = 1'b0;
      if (!m_busy) begin
        if (en) begin
          m_busy = 1'b1;
          m_pos  = 0;
          m_cnt  = 0;
        end
      end else begin
        tot = m_cnt + int'(pulse);
        if (m_pos == G - 1) begin
          m_freq  = (tot > CntMax) ? CntMax : tot;
          m_ovf   = (tot > CntMax);
          m_valid = 1'b1;
          m_pos   = 0;
          m_cnt   = 0;
          if (!en) m_busy = 1'b0;
        end else if (!en) begin
          m_busy = 1'b0;
        end else begin
          m_pos++;
          m_cnt = tot;
        end
      end
    end
    @(negedge clki);
    check_eq("valid", valid_o, m_valid);
    check_eq("busy", busy_o, m_busy);
    check_eq("freq", freq_o, m_freq);
    check_eq("ovf", ovf_o, m_ovf);
    if (m_valid && dir_kind != 0) begin
      if (dir_skip > 0) begin
        dir_skip--;
      end else begin
        case (dir_kind)
          1: begin
            check_eq("p10_freq", freq_o, 100);
            check_eq("p10_ovf", ovf_o, 0);
          end
          2: check_eq("const0_freq", freq_o, 0);
          3: check_eq("p4_freq_pm1", (freq_o >= 249 && freq_o <= 251), 1);
          4: begin
            check_eq("p2_freq", freq_o, 255);
            check_eq("p2_ovf", ovf_o, 1);
          end
          default: ;
        endcase
      end
    end
    next_sig();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Advance until the model is in the given window position; a timeout counts as a failure.
  task automatic wait_pos(input int pos, input string tag);
    int n;
    n = 0;
    while (!(m_busy && m_pos == pos) && n < 2 * G) begin
      tick();
      n++;
    end
    check_eq(tag, (m_busy && m_pos == pos), 1);
  endtask

  task automatic measure_latency(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_o && n < G + 100);
    check_eq(tag, n, G + 1);
  endtask

  initial begin
    model_reset();
    rnd_left = 0;
    set_mode(0, 0, 0);

    #12;
    check_eq("rst_freq", freq_o, 0);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_ovf", ovf_o, 0);
    check_eq("rst_busy", busy_o, 0);
    @(negedge clki);
    rst_n = 1'b1;
    run(3);

    en = 1'b1;
    set_mode(1, 10, 1);
    run(4100);
    set_mode(0, 0, 2);
    run(3100);
    set_mode(1, 4, 3);
    run(4100);
    set_mode(1, 2, 4);
    run(4100);

    // Abort mid-window, then restart and time the next result.
    set_mode(1, 10, 0);
    run(1500);
    wait_pos(499, "reach_mid");
    en = 1'b0;
    run(30);
    check_eq("abort_hold", freq_o, 100);
    en = 1'b1;
    measure_latency("restart_lat");

    // Drop en exactly on the terminal cycle: the window must still complete.
    wait_pos(G - 1, "reach_term");
    en = 1'b0;
    run(1);
    check_eq("term_valid", valid_o, 1);
    run(10);
    en = 1'b1;

    set_mode(2, 0, 0);
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 999) == 0) en = ~en;
    end
    en = 1'b1;
    set_mode(1, 10, 0);
    run(1400);

    // Asynchronous reset in the middle of a window.
    @(posedge clki);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst_freq", freq_o, 0);
    check_eq("arst_valid", valid_o, 0);
    check_eq("arst_ovf", ovf_o, 0);
    check_eq("arst_busy", busy_o, 0);
    @(negedge clki);
    run(2);
    rst_n = 1'b1;
    measure_latency("post_rst_lat");
    check_eq("post_rst_freq", freq_o, 100);
    run(1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
